sw_debounce_sync: RTL and testbench

Input-conditioning stage between the board slide switches (SW15..SW0) and the adder/subtractor top level. It synchronises every raw switch bit into the CLK domain, debounces each bit independently with a stability counter, and presents a clean vector plus one-cycle rise/fall/change pulses. The clean vector drives the operand nibbles (SW15..SW12, SW11..SW8), the add/sub select (SW0) and the display-select bits (SW2..SW1). The pulses let downstream logic react to an edit exactly once.

---
 rtl/sw_debounce_sync.sv | 77 +++++++
 tb/tb_sw_debounce_sync.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: two-flop synchroniser per bit, independent per-bit
// stability counter, registered clean levels and one-cycle rise/fall/change pulses.
module sw_debounce_sync #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_clean_nxt;

  // A sample equal to the clean level restarts the count; the flip happens on
  // the edge that would otherwise push the counter past CNT_LAST.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_clean[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_flip[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
    w_clean_nxt = r_clean ^ w_flip;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_clean   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= sw_raw;
      r_sync2   <= r_sync1;
      r_clean   <= w_clean_nxt;
      r_rise    <= w_flip & ~r_clean;
      r_fall    <= w_flip & r_clean;
      r_changed <= |w_flip;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign sw_clean   = r_clean;
  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign sw_changed = r_changed;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync with STABLE_CYCLES=4: the driver queues each hand-computed
// clean flip, and a negedge monitor matches every pulse against the queue head.
module tb_sw_debounce_sync;

  localparam int W = 16;
  localparam int S = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  sw_debounce_sync #(
    .WIDTH        (W),
    .STABLE_CYCLES(S)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 CLK = ~CLK;

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {edge index, clean, rise, fall}
  logic [79:0]  exp_q[$];
  logic [W-1:0] exp_clean = '0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_flip(input int at, input logic [W-1:0] c,
                             input logic [W-1:0] r, input logic [W-1:0] f);
    exp_q.push_back({32'(at), c, r, f});
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [79:0] e;
    if (rst_q) begin
      check("reset_clean", 32'(sw_clean), 32'd0);
      check("reset_rise", 32'(sw_rise), 32'd0);
      check("reset_fall", 32'(sw_fall), 32'd0);
      check("reset_changed", 32'(sw_changed), 32'd0);
      exp_clean = '0;
    end else if (sw_changed || (|sw_rise) || (|sw_fall)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: rise %h fall %h changed %b, expected none (cycle %0d)",
                 sw_rise, sw_fall, sw_changed, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), e[79:48]);
        check("pulse_clean", 32'(sw_clean), 32'(e[47:32]));
        check("pulse_rise", 32'(sw_rise), 32'(e[31:16]));
        check("pulse_fall", 32'(sw_fall), 32'(e[15:0]));
        check("pulse_changed", 32'(sw_changed), 32'd1);
        exp_clean = e[47:32];
      end
    end else begin
      check("hold_clean", 32'(sw_clean), 32'(exp_clean));
      if (exp_q.size() != 0 && int'(exp_q[0][79:48]) < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse: no change seen, expected clean %h at cycle %0d (now %0d)",
                 e[47:32], e[79:48], cyc);
        exp_clean = e[47:32];
      end
    end
  end

  // ---------------- stimulus ----------------
  // A level set after edge cyc is first sampled at cyc+1 and flips S+1 edges later.
  initial begin
    sw_raw = 16'hFFFF;
    RST    = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    expect_flip(cyc + 6, 16'hFFFF, 16'hFFFF, 16'h0000);
    repeat (8) step();

    sw_raw = 16'hA501;
    expect_flip(cyc + 6, 16'hA501, 16'h0000, 16'h5AFE);
    repeat (8) step();

    sw_raw = 16'h5A01;
    expect_flip(cyc + 6, 16'h5A01, 16'h5A00, 16'hA500);
    repeat (8) step();

    sw_raw = 16'h5A00;
    expect_flip(cyc + 6, 16'h5A00, 16'h0000, 16'h0001);
    repeat (8) step();
    sw_raw = 16'h5A01;
    expect_flip(cyc + 6, 16'h5A01, 16'h0001, 16'h0000);
    repeat (8) step();

    sw_raw = 16'h4A01;
    expect_flip(cyc + 6, 16'h4A01, 16'h0000, 16'h1000);
    repeat (8) step();

    // Three mismatching samples then one match: counter peaks at S-1, never flips.
    for (int i = 0; i < 40; i++) begin
      sw_raw[12] = (i % 4 != 3);
      step();
    end
    repeat (8) step();

    sw_raw = 16'h4B01;
    repeat (3) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    expect_flip(cyc + 6, 16'h4B01, 16'h4B01, 16'h0000);
    repeat (8) step();

    sw_raw = 16'h4B03 | 16'h0004;
    expect_flip(cyc + 6, 16'h4B03, 16'h0002, 16'h0000);
    for (int i = 1; i < 30; i++) begin
      step();
      sw_raw = (i % 2 == 1) ? 16'h4B03 : (16'h4B03 | 16'h0004);
    end
    repeat (8) step();

    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
